// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer and datapath: IR field positions,
// opcodes, alu_op bit order and the sequencer state encoding.
package cpu_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int REG_SEL_W = 4;

  localparam int ALU_W    = 13;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_SHR  = 4;
  localparam int ALU_SHRA = 5;
  localparam int ALU_SHL  = 6;
  localparam int ALU_ROR  = 7;
  localparam int ALU_ROL  = 8;
  localparam int ALU_MUL  = 9;
  localparam int ALU_DIV  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_ROR  = 5'b00111;
  localparam logic [4:0] OPC_ROL  = 5'b01000;
  localparam logic [4:0] OPC_SHR  = 5'b01001;
  localparam logic [4:0] OPC_SHRA = 5'b01010;
  localparam logic [4:0] OPC_SHL  = 5'b01011;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  typedef struct packed {
    logic             vld;
    logic             unary;
    logic             mul_div;
    logic [ALU_W-1:0] alu_mask;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [4:0] opc);
    op_info_t info;
    info = '{vld: 1'b1, unary: 1'b0, mul_div: 1'b0, alu_mask: '0};
    case (opc)
      OPC_ADD:  info.alu_mask[ALU_ADD]  = 1'b1;
      OPC_SUB:  info.alu_mask[ALU_SUB]  = 1'b1;
      OPC_AND:  info.alu_mask[ALU_AND]  = 1'b1;
      OPC_OR:   info.alu_mask[ALU_OR]   = 1'b1;
      OPC_ROR:  info.alu_mask[ALU_ROR]  = 1'b1;
      OPC_ROL:  info.alu_mask[ALU_ROL]  = 1'b1;
      OPC_SHR:  info.alu_mask[ALU_SHR]  = 1'b1;
      OPC_SHRA: info.alu_mask[ALU_SHRA] = 1'b1;
      OPC_SHL:  info.alu_mask[ALU_SHL]  = 1'b1;
      OPC_MUL: begin info.alu_mask[ALU_MUL] = 1'b1; info.mul_div = 1'b1; end
      OPC_DIV: begin info.alu_mask[ALU_DIV] = 1'b1; info.mul_div = 1'b1; end
      OPC_NEG: begin info.alu_mask[ALU_NEG] = 1'b1; info.unary = 1'b1; end
      OPC_NOT: begin info.alu_mask[ALU_NOT] = 1'b1; info.unary = 1'b1; end
      default: info.vld = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/reg_decoder.sv
// Binary register select to one-hot enable vector; all zeros when disabled
// or when the select addresses a register that does not exist.
module reg_decoder #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for R-format ALU instructions.
// Strobes are a Moore decode of the state register and the IR fields.
module control_unit
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         IR,
  input  logic                stop,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [ALU_W-1:0]    alu_op,
  output logic                run,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  state_t               state;
  op_info_t             info;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic [REG_SEL_W-1:0] rout_sel;
  logic                 rin_en, rout_en;
  logic                 unused_ir;

  assign ra        = IR[RA_HI:RA_LO];
  assign rb        = IR[RB_HI:RB_LO];
  assign rc        = IR[RC_HI:RC_LO];
  assign info      = decode_op(IR[OP_HI:OP_LO]);
  assign unused_ir = ^IR[RC_LO-1:0];
  assign run       = (state != ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RST;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_RST: state <= ST_T0;
        ST_T0:  state <= ST_T1;
        ST_T1:  state <= ST_T2;
        ST_T2:  state <= ST_T3;
        ST_T3: begin
          if (!info.vld) begin
            illegal <= 1'b1;
            state   <= ST_HALT;
          end else begin
            state <= ST_T4;
          end
        end
        ST_T4: state <= ST_T5;
        ST_T5: begin
          if (info.mul_div) begin
            state <= ST_T6;
          end else begin
            instr_count <= instr_count + CNT_W'(1);
            state       <= stop ? ST_HALT : ST_T0;
          end
        end
        ST_T6: begin
          instr_count <= instr_count + CNT_W'(1);
          state       <= stop ? ST_HALT : ST_T0;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    alu_op   = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb;
    case (state)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
      end
      ST_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        // Unary ops take their operand in T4, so T3 is idle for them.
        if (info.vld && !info.unary) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
        end
      end
      ST_T4: begin
        if (info.vld) begin
          rout_en  = 1'b1;
          rout_sel = info.unary ? rb : rc;
          alu_op   = info.alu_mask;
          Zin      = 1'b1;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        LOin    = info.mul_div;
        rin_en  = !info.mul_div;
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(REG_SEL_W)) u_rin_dec (
    .en     (rin_en),
    .sel    (ra),
    .onehot (Rin)
  );

  reg_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(REG_SEL_W)) u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one 32-bit-counter instance plus a 2-bit
// counter instance on the same stimulus to exercise counter wrap.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        stop;

  logic [15:0] Rin, Rout, w_Rin, w_Rout;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic        w_PCout, w_PCin, w_IncPC, w_MARin, w_Read, w_MDRin, w_MDRout, w_IRin;
  logic        w_Yin, w_Zin, w_Zlowout, w_Zhighout, w_HIin, w_LOin;
  logic [12:0] alu_op, w_alu_op;
  logic        run, illegal, w_run, w_illegal;
  logic [31:0] instr_count;
  logic [1:0]  w_instr_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0_cyc;

  // Strobe vector bit order (MSB first): PCout PCin IncPC MARin Read MDRin MDRout IRin Yin Zin Zlowout Zhighout HIin LOin
  localparam logic [13:0] S_FETCH0 = 14'b1111_0000_0000_00;
  localparam logic [13:0] S_FETCH1 = 14'b0000_1100_0000_00;
  localparam logic [13:0] S_FETCH2 = 14'b0000_0011_0000_00;
  localparam logic [13:0] S_YIN    = 14'b0000_0000_1000_00;
  localparam logic [13:0] S_ZIN    = 14'b0000_0000_0100_00;
  localparam logic [13:0] S_ZLO_R  = 14'b0000_0000_0010_00;
  localparam logic [13:0] S_ZLO_LO = 14'b0000_0000_0010_01;
  localparam logic [13:0] S_ZHI_HI = 14'b0000_0000_0001_10;
  localparam logic [13:0] S_NONE   = 14'b0;

  logic [13:0] strobes;
  assign strobes = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                    Yin, Zin, Zlowout, Zhighout, HIin, LOin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_unit #(.NUM_REGS(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .IR(IR), .stop(stop),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .alu_op(alu_op), .run(run), .illegal(illegal), .instr_count(instr_count)
  );

  control_unit #(.NUM_REGS(16), .CNT_W(2)) u_wrap (
    .clk(clk), .reset(reset), .IR(IR), .stop(stop),
    .Rin(w_Rin), .Rout(w_Rout),
    .PCout(w_PCout), .PCin(w_PCin), .IncPC(w_IncPC), .MARin(w_MARin), .Read(w_Read),
    .MDRin(w_MDRin), .MDRout(w_MDRout), .IRin(w_IRin), .Yin(w_Yin), .Zin(w_Zin),
    .Zlowout(w_Zlowout), .Zhighout(w_Zhighout), .HIin(w_HIin), .LOin(w_LOin),
    .alu_op(w_alu_op), .run(w_run), .illegal(w_illegal), .instr_count(w_instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_step(input string tag, input logic [13:0] s, input logic [15:0] rin,
                          input logic [15:0] rout, input logic [12:0] alu);
    chk({tag, ".strobes"}, 32'(strobes), 32'(s));
    chk({tag, ".Rin"},     32'(Rin),     32'(rin));
    chk({tag, ".Rout"},    32'(Rout),    32'(rout));
    chk({tag, ".alu_op"},  32'(alu_op),  32'(alu));
  endtask

  // Call while in T0; returns in T3 with IR presented during T2.
  task automatic fetch(input string tag, input logic [31:0] ir);
    chk_step({tag, ".T0"}, S_FETCH0, 16'h0, 16'h0, 13'h0);
    tick();
    chk_step({tag, ".T1"}, S_FETCH1, 16'h0, 16'h0, 13'h0);
    tick();
    chk_step({tag, ".T2"}, S_FETCH2, 16'h0, 16'h0, 13'h0);
    IR = ir;
    tick();
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  initial begin
    reset = 1'b1;
    IR    = 32'h0;
    stop  = 1'b0;
    tick();
    tick();
    chk_step("reset", S_NONE, 16'h0, 16'h0, 13'h0);
    chk("reset.run", 32'(run), 32'd1);
    chk("reset.illegal", 32'(illegal), 32'd0);
    chk("reset.count", instr_count, 32'd0);

    // SHL r4 = r3 << r7
    reset = 1'b0;
    tick();
    fetch("shl", 32'h5A1B8000);
    chk_step("shl.T3", S_YIN, 16'h0, 16'h0008, 13'h0);
    tick();
    chk_step("shl.T4", S_ZIN, 16'h0, 16'h0080, 13'h0040);
    tick();
    chk_step("shl.T5", S_ZLO_R, 16'h0010, 16'h0, 13'h0);
    chk("shl.count_before", instr_count, 32'd0);
    tick();
    chk("shl.count_after", instr_count, 32'd1);

    // MUL rb=2, rc=5: seven-cycle instruction
    t0_cyc = cyc;
    fetch("mul", mk_ir(5'b01111, 4'd6, 4'd2, 4'd5));
    chk_step("mul.T3", S_YIN, 16'h0, 16'h0004, 13'h0);
    tick();
    chk_step("mul.T4", S_ZIN, 16'h0, 16'h0020, 13'h0200);
    tick();
    chk_step("mul.T5", S_ZLO_LO, 16'h0, 16'h0, 13'h0);
    tick();
    chk_step("mul.T6", S_ZHI_HI, 16'h0, 16'h0, 13'h0);
    chk("mul.count_T6", instr_count, 32'd1);
    tick();
    chk("mul.t0_spacing", 32'(cyc - t0_cyc), 32'd7);
    chk("mul.count_after", instr_count, 32'd2);

    // NOT r1 = ~r9
    fetch("not", mk_ir(5'b10010, 4'd1, 4'd9, 4'd0));
    chk_step("not.T3", S_NONE, 16'h0, 16'h0, 13'h0);
    tick();
    chk_step("not.T4", S_ZIN, 16'h0, 16'h0200, 13'h1000);
    tick();
    chk_step("not.T5", S_ZLO_R, 16'h0002, 16'h0, 13'h0);
    tick();
    chk("not.count_after", instr_count, 32'd3);
    chk("wrap.count3", 32'(w_instr_count), 32'd3);

    // ADD r5 = r1 + r2 with stop raised during T2
    chk_step("add.T0", S_FETCH0, 16'h0, 16'h0, 13'h0);
    tick();
    tick();
    stop = 1'b1;
    IR   = mk_ir(5'b00011, 4'd5, 4'd1, 4'd2);
    tick();
    chk_step("add.T3", S_YIN, 16'h0, 16'h0002, 13'h0);
    tick();
    chk_step("add.T4", S_ZIN, 16'h0, 16'h0004, 13'h0001);
    tick();
    chk_step("add.T5", S_ZLO_R, 16'h0020, 16'h0, 13'h0);
    chk("add.run_T5", 32'(run), 32'd1);
    tick();
    chk("stop.run", 32'(run), 32'd0);
    chk("stop.count", instr_count, 32'd4);
    chk("wrap.count_to_zero", 32'(w_instr_count), 32'd0);
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stop.halt_strobes", 32'(strobes), 32'(S_NONE));
    end
    chk("stop.still_halted", 32'(run), 32'd0);

    // Leave HALT via reset, then reset again in T4 of a SUB
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fetch("sub", mk_ir(5'b00100, 4'd2, 4'd3, 4'd4));
    tick();
    chk_step("sub.T4", S_ZIN, 16'h0, 16'h0010, 13'h0002);
    reset = 1'b1;
    tick();
    chk_step("midrst", S_NONE, 16'h0, 16'h0, 13'h0);
    chk("midrst.count", instr_count, 32'd0);
    chk("midrst.run", 32'(run), 32'd1);
    reset = 1'b0;
    tick();
    chk_step("midrst.T0", S_FETCH0, 16'h0, 16'h0, 13'h0);

    // Illegal opcode 11111
    fetch("ill", mk_ir(5'b11111, 4'd1, 4'd2, 4'd3));
    chk_step("ill.T3", S_NONE, 16'h0, 16'h0, 13'h0);
    chk("ill.flag_T3", 32'(illegal), 32'd0);
    tick();
    chk("ill.flag", 32'(illegal), 32'd1);
    chk("ill.run", 32'(run), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk_step("ill.halt", S_NONE, 16'h0, 16'h0, 13'h0);
      tick();
    end
    chk("ill.count", instr_count, 32'd0);
    chk("ill.sticky", 32'(illegal), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer that sits directly upstream of `datapath` and drives every one of its control inputs. Each instruction runs as fetch, then decode, then an ALU register-register (R-format) execute sequence. The block reads the IR contents back from the datapath and retires one instruction per 6 or 7 cycles. It replaces hand-driven testbench sequencing with an FSM that produces identical T-step signal patterns.

## Interface
- `NUM_REGS`, 16: general register count (sizes `Rin`/`Rout`)
- `CNT_W`, 32: width of `instr_count`
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `IR`  in  32  instruction register contents from datapath
- `stop`  in  1  level; request halt at next instruction boundary
- `Rin`  out  16  one-hot register load enables (bit n = Rn in)
- `Rout`  out  16  one-hot register bus drivers (bit n = Rn out)
- `PCout`, `PCin`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `Zhighout`, `HIin`, `LOin`  out  1 each  datapath strobes
- `alu_op`  out  13  one-hot ALU select; bits 0..12 = ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,MUL,DIV,NEG,NOT
- `run`  out  1  high unless halted
- `illegal`  out  1  sticky; set by an undefined opcode
- `instr_count`  out  CNT_W  retired-instruction counter

## Operation
- IR fields: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15].
- Opcode map: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 ROR, 01000 ROL, 01001 SHR, 01010 SHRA, 01011 SHL, 01111 MUL, 10000 DIV, 10001 NEG, 10010 NOT. All other opcodes are illegal.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- RST: all outputs 0. Next state is T0.
- T0: PCout, MARin, IncPC, PCin.
- T1: Read, MDRin.
- T2: MDRout, IRin. IR is valid from T3 onward.
- T3:
  - Binary ops: Rout[rb], Yin.
  - NEG/NOT: no strobes.
  - Illegal opcode: no strobes. Set `illegal`, next state HALT.
- T4:
  - Binary ops: Rout[rc], alu_op bit, Zin.
  - NEG/NOT: Rout[rb], alu_op bit, Zin.
- T5:
  - MUL/DIV: Zlowout, LOin. Next state T6.
  - Other ops: Zlowout, Rin[ra]. Instruction retires.
- T6 (MUL/DIV only): Zhighout, HIin. Instruction retires.
- Retire:
  - `instr_count` increments by 1, wrapping at 2^CNT_W-1 to 0.
  - If `stop` is sampled high in the retire cycle, next state is HALT. Otherwise next state is T0.
  - `stop` asserted mid-instruction has no effect until retire.
- HALT: all strobes 0, `run`=0. Only `reset` exits HALT.
- At most one bit of `Rin`, `Rout` and `alu_op` is high in any cycle.
- Exactly one bus driver is active in T0, T2, T3 (binary), T4, T5 and T6.

## Timing
- All outputs are a Moore decode of the state register plus IR fields. They are valid for the whole state cycle and take effect at the datapath's next rising edge.
- Reset values: state RST, all strobes 0, `alu_op`=0, `run`=1, `illegal`=0, `instr_count`=0.
- `reset` wins over every other event in the same cycle, including a mid-instruction state.
- Instruction latency:
  - ALU ops: 6 cycles (T0..T5).
  - MUL/DIV: 7 cycles (T0..T6).
  - The first T0 occurs 1 cycle after reset deasserts.
- `illegal` sets at the end of T3. HALT is entered the next cycle.
- `instr_count` does not increment for an illegal opcode.
- `stop` is sampled only in the retire cycle (T5, or T6 for MUL/DIV).
- With `stop` already high at reset release, the first instruction still completes, then the FSM halts.

## Structure
- Package `cpu_pkg`: opcode localparams, state enum encoding, `alu_op` bit indices, IR field bit positions. `datapath` shares the same alu_op ordering.
- Sub-module `reg_decoder` (4-to-16 one-hot with enable), instantiated twice: once for `Rin` and once for `Rout`.
- The FSM next-state logic and output decode stay in `control_unit`.

## Test plan
- SHL: IR=0x5A1B8000 (ra=4, rb=3, rc=7) returned after T2 -> T3 Rout=0x0008, Yin; T4 Rout=0x0080, alu_op bit 6, Zin; T5 Zlowout, Rin=0x0010; `instr_count` 0->1.
- MUL: IR opcode 01111, rb=2, rc=5 -> T4 alu_op bit 9; T5 LOin, Rin=0; T6 Zhighout, HIin; next T0 is 7 cycles after the previous T0.
- NOT: opcode 10010, ra=1, rb=9 -> T3 no strobes; T4 Rout=0x0200, alu_op bit 12; T5 Rin=0x0002.
- Illegal: opcode 11111 -> `illegal`=1 after T3, `run`=0, strobes stay 0 for 20 cycles, `instr_count` unchanged.
- Stop: `stop` raised at T2 of an ADD -> T5 completes with Rin[ra], `instr_count`+1, then HALT with no further T0.
- Reset mid-instruction: `reset` asserted in T4 -> next cycle RST with all outputs 0 and `instr_count`=0; T0 follows; with `instr_count` preset to 0xFFFFFFFF, a retire wraps it to 0.
